arb_mux: RTL and testbench

ARB_MUX -- requirements
Module: arb_mux

---
 rtl/arb_mux.sv | 194 +++++++++++++++++++
 tb/tb_arb_mux.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux.sv
// Purpose     : N-channel arbiter/mux into a single registered output slot (fixed-select or round-robin).
// Latency     : one cycle; a word accepted on an input appears on Out in the following cycle.
// Backpressure: the slot reloads while draining, so one word per cycle passes with OutReady=1; OutReady=0 while full stalls all inputs.
//
// Ports
//   clk, rst_n        single clock, asynchronous active-low reset
//   Mode              0 = fixed select on SEL, 1 = round-robin from the internal pointer
//   SEL               channel index for Mode=0 (values >= N select nothing)
//   In / InValid      packed channel data (channel k at [k*W +: W]) and per-channel valid
//   InReady           one-hot (or zero) ready to the granted channel, combinational
//   Out/OutValid/OutCh registered output word, its valid and its source channel
//   OutReady          downstream ready
//   Count             (only with ARB_MUX_CNT_EN) saturating 16-bit count of accepted input words
//
// Build option: define ARB_MUX_CNT_EN to add the Count output and its counter.

module arb_mux #(
    parameter  int W  = 32,
    parameter  int N  = 4,
    localparam int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Mode,
    input  logic [SW-1:0]   SEL,
    input  logic [N*W-1:0]  In,
    input  logic [N-1:0]    InValid,
    output logic [N-1:0]    InReady,
    output logic [W-1:0]    Out,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [SW-1:0]   OutCh
`ifdef ARB_MUX_CNT_EN
    ,
    output logic [15:0]     Count
`endif
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [W-1:0]    out_q;
    logic [SW-1:0]   ch_q;
    logic [SW-1:0]   ptr_q;

    logic            rr_vld;
    logic [SW-1:0]   rr_idx;
    logic            fx_vld;
    logic            gnt_vld;
    logic [SW-1:0]   gnt_idx;
    logic [W-1:0]    gnt_dat;
    logic            can_load;
    logic            load;

    // ------------------------------------------------------------------
    // Round-robin search: first valid channel at or above ptr_q, wrapping
    // from N-1 back to 0. The offset loop keeps the priority rotation
    // explicit instead of building a doubled request vector.
    // ------------------------------------------------------------------
    always_comb begin
        rr_vld = 1'b0;
        rr_idx = '0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = int'(ptr_q) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!rr_vld && InValid[SW'(j)]) begin
                rr_vld = 1'b1;
                rr_idx = SW'(j);
            end
        end
    end

    // Fixed select: an out-of-range SEL (possible when N is not a power
    // of two) yields no candidate at all.
    always_comb begin
        fx_vld = 1'b0;
        if (int'(SEL) < N) begin
            fx_vld = InValid[SEL];
        end
    end

    always_comb begin
        gnt_vld = Mode ? rr_vld : fx_vld;
        gnt_idx = Mode ? rr_idx : SEL;
    end

    // The slot accepts a new word when empty, or when the current word
    // leaves in this same cycle.
    always_comb begin
        can_load = (state_q == ST_EMPTY) || OutReady;
        load     = can_load && gnt_vld;
    end

    always_comb begin
        InReady = '0;
        if (load) begin
            InReady = N'(1) << gnt_idx;
        end
    end

    always_comb begin
        gnt_dat = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt_idx == SW'(k)) begin
                gnt_dat = In[k*W +: W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output slot state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (load) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                // A reload while draining keeps the slot full.
                if (!load && OutReady) begin
                    state_d = ST_EMPTY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and pointer. Out/OutCh only change on a load, so the held
    // word stays stable across stalls and Mode/SEL changes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            ch_q  <= '0;
        end else if (load) begin
            out_q <= gnt_dat;
            ch_q  <= gnt_idx;
        end
    end

    // Pointer moves just past the winner, and only for round-robin grants.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (load && Mode) begin
            if (gnt_idx == SW'(N - 1)) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= gnt_idx + SW'(1);
            end
        end
    end

`ifdef ARB_MUX_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign Count = cnt_q;
`endif

    assign Out      = out_q;
    assign OutValid = (state_q == ST_FULL);
    assign OutCh    = ch_q;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux (W=32, N=4): directed vectors, a behavioural model of the
// output slot checked every cycle, and hand-computed literal expectations.
// Summary line: CHECKS <n> ERRORS <n>.

module tb_arb_mux;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int SW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            Mode;
    logic [SW-1:0]   SEL;
    logic [N*W-1:0]  In;
    logic [N-1:0]    InValid;
    logic [N-1:0]    InReady;
    logic [W-1:0]    Out;
    logic            OutValid;
    logic            OutReady;
    logic [SW-1:0]   OutCh;
`ifdef ARB_MUX_CNT_EN
    logic [15:0]     Count;
`endif

    arb_mux #(.W(W), .N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Mode     (Mode),
        .SEL      (SEL),
        .In       (In),
        .InValid  (InValid),
        .InReady  (InReady),
        .Out      (Out),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutCh    (OutCh)
`ifdef ARB_MUX_CNT_EN
        ,
        .Count    (Count)
`endif
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: the slot holds at most one word; the winner is the
    // selected channel (fixed) or the first valid channel counting up from
    // the pointer (round-robin).
    // ------------------------------------------------------------------
    logic [W-1:0]  m_out;
    logic [SW-1:0] m_ch;
    logic          m_vld;
    int            m_ptr;
    int            m_cnt;
    int            mg;
    logic [N-1:0]  m_rdy;

    function automatic int grant_of(input logic mode, input logic [SW-1:0] sel,
                                    input logic [N-1:0] v, input int ptr);
        if (!mode) begin
            if (int'(sel) < N && v[sel]) return int'(sel);
            return -1;
        end
        for (int d = 0; d < N; d++) begin
            if (v[(ptr + d) % N]) return (ptr + d) % N;
        end
        return -1;
    endfunction

    always_comb begin
        mg    = grant_of(Mode, SEL, InValid, m_ptr);
        m_rdy = '0;
        if (mg >= 0 && (!m_vld || OutReady)) begin
            m_rdy = N'(1) << mg;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out <= '0;
            m_ch  <= '0;
            m_vld <= 1'b0;
            m_ptr <= 0;
            m_cnt <= 0;
        end else if (mg >= 0 && (!m_vld || OutReady)) begin
            m_out <= In[mg*W +: W];
            m_ch  <= SW'(mg);
            m_vld <= 1'b1;
            if (Mode) m_ptr <= (mg + 1) % N;
            if (m_cnt < 65535) m_cnt <= m_cnt + 1;
        end else if (OutReady) begin
            m_vld <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Literal expectations posted by the stimulus, consumed by the compare
    // process at its next sample point.
    // ------------------------------------------------------------------
    int            pin_seq = 0;
    int            pin_done = 0;
    string         pin_name;
    logic [W-1:0]  pin_out;
    logic [SW-1:0] pin_ch;
    logic          pin_vld;
    logic [N-1:0]  pin_rdy;

    task automatic pin(input string nm, input logic [W-1:0] o, input int ch,
                       input logic v, input logic [N-1:0] r);
        pin_name = nm;
        pin_out  = o;
        pin_ch   = SW'(ch);
        pin_vld  = v;
        pin_rdy  = r;
        pin_seq  = pin_seq + 1;
    endtask

    // ------------------------------------------------------------------
    // Compare process: samples 1 time unit after each falling clock edge and
    // after any reset assertion (to observe the asynchronous clear).
    // ------------------------------------------------------------------
    int   checks = 0;
    int   errors = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always begin
        @(negedge clk or negedge rst_n);
        #1;
        if (chk_en) begin
            chk("model_InReady",  64'(InReady),  64'(m_rdy));
            chk("model_OutValid", 64'(OutValid), 64'(m_vld));
            chk("model_Out",      64'(Out),      64'(m_out));
            chk("model_OutCh",    64'(OutCh),    64'(m_ch));
`ifdef ARB_MUX_CNT_EN
            chk("model_Count",    64'(Count),    64'(m_cnt));
`endif
            if (pin_seq != pin_done) begin
                chk({pin_name, "_InReady"},  64'(InReady),  64'(pin_rdy));
                chk({pin_name, "_OutValid"}, 64'(OutValid), 64'(pin_vld));
                chk({pin_name, "_Out"},      64'(Out),      64'(pin_out));
                chk({pin_name, "_OutCh"},    64'(OutCh),    64'(pin_ch));
                pin_done = pin_seq;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [W-1:0] d [N];
    logic [7:0]   vec [10];   // {Mode, SEL[1:0], InValid[3:0], OutReady}

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_data();
        for (int k = 0; k < N; k++) In[k*W +: W] = d[k];
    endtask

    initial begin
        Mode = 1'b0; SEL = '0; In = '0; InValid = '0; OutReady = 1'b0;
        for (int k = 0; k < N; k++) d[k] = 32'hC0DE_0000 + 32'(k) * 32'h0000_1111;

        vec[0] = 8'b1_00_1010_1;
        vec[1] = 8'b1_00_1010_0;
        vec[2] = 8'b1_00_1010_1;
        vec[3] = 8'b0_01_0011_1;
        vec[4] = 8'b0_11_0011_1;
        vec[5] = 8'b1_10_1001_1;
        vec[6] = 8'b1_00_0000_1;
        vec[7] = 8'b0_00_0001_0;
        vec[8] = 8'b0_00_0001_1;
        vec[9] = 8'b1_00_1111_1;

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        pin("reset", '0, 0, 1'b0, 4'b0000);

        // Fixed select on channel 2, first edge after release.
        step();
        rst_n = 1'b1;
        In[2*W +: W] = 32'hA5A5_A5A5;
        Mode = 1'b0; SEL = 2'd2; InValid = 4'b0100; OutReady = 1'b1;
        pin("sel2_rdy", '0, 0, 1'b0, 4'b0100);
        step();
        InValid = 4'b0000;
        pin("sel2_out", 32'hA5A5_A5A5, 2, 1'b1, 4'b0000);

        // No candidate: slot drains. Then round-robin with all valid.
        step();
        Mode = 1'b1; load_data(); InValid = 4'b1111;
        pin("drain", 32'hA5A5_A5A5, 2, 1'b0, 4'b0001);
        for (int i = 0; i < 6; i++) begin
            step();
            pin("rr_seq", d[i % N], i % N, 1'b1, N'(1) << ((i + 1) % N));
        end

        // Stall with a full slot; Mode/SEL change while held.
        for (int h = 0; h < 3; h++) begin
            step();
            OutReady = 1'b0;
            if (h == 2) begin
                Mode = 1'b0; SEL = 2'd3;
            end
            pin("hold", d[2], 2, 1'b1, 4'b0000);
        end
        step();
        OutReady = 1'b1;
        pin("release", d[2], 2, 1'b1, 4'b1000);

        // Pointer at 3 (fixed-mode grant left it alone), only ch1 valid.
        step();
        Mode = 1'b1; InValid = 4'b0010;
        pin("wrap_grant", d[3], 3, 1'b1, 4'b0010);
        step();
        InValid = 4'b1111;
        pin("ptr_after_wrap", d[1], 1, 1'b1, 4'b0100);

        // Asynchronous reset while full.
        step();
        OutReady = 1'b0; InValid = 4'b0000;
        pin("pre_reset", d[2], 2, 1'b1, 4'b0000);
        step();
        #1;
        pin("async_reset", '0, 0, 1'b0, 4'b0000);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        Mode = 1'b1; InValid = 4'b1111; OutReady = 1'b1;
        pin("post_reset", '0, 0, 1'b0, 4'b0001);
        step();
        pin("first_after_reset", d[0], 0, 1'b1, 4'b0010);

        // Mixed patterns, model-checked.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) begin
                step();
                for (int k = 0; k < N; k++) In[k*W +: W] = 32'(k + 1) * 32'h1000_0000 + 32'(r * 16 + i);
                Mode     = vec[i][7];
                SEL      = vec[i][6:5];
                InValid  = vec[i][4:1];
                OutReady = vec[i][0];
            end
        end

`ifdef ARB_MUX_CNT_EN
        Mode = 1'b1; InValid = 4'b1111; OutReady = 1'b1;
        repeat (70000) step();
        step();
        pin("count_sat", m_out, int'(m_ch), 1'b1, m_rdy);
`endif

        step();
        step();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
